gcm_ghash_ds: RTL and testbench

- Parametrised GHASH/tag engine for the GCM datapath. Accumulates AAD and ciphertext blocks through a digit-serial GF(2^128) multiplier and appends the length block. XORs the result with E(K,J0) to produce the tag.
- Generalises the single-width tag path with:
  - configurable multiplier digit width (area/throughput trade),
  - partial-block byte masking,
  - a decrypt mode that compares against a supplied tag.
- Sits downstream of the AES core, which supplies H, E(K,J0) and the ciphertext blocks.

---
 rtl/gcm_pkg.sv | 34 +++
 rtl/gcm_gf128_mul_ds.sv | 58 +++++
 rtl/gcm_ghash_ds.sv | 175 +++++++++++++++++
 tb/tb_gcm_ghash_ds.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcm_pkg.sv
// Shared types and GF(2^128) helpers for the GCM GHASH/tag datapath.
// Bit 127 of a block is the leftmost (first) bit of the GCM bit string.
package gcm_pkg;

    typedef logic [127:0] blk_t;

    localparam blk_t GCM_R = {8'he1, 120'h0};

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        MULT,
        LENMUL,
        FINAL
    } ghash_state_e;

    typedef struct packed {
        blk_t z;
        blk_t v;
    } gf_zv_t;

    // One iteration of the right-shift multiply: accumulate V when the X bit is set, then V = V*x.
    function automatic gf_zv_t gf128_step(input gf_zv_t zv, input logic xbit);
        gf_zv_t r;
        r.z = xbit ? (zv.z ^ zv.v) : zv.z;
        r.v = (zv.v >> 1) ^ (zv.v[0] ? GCM_R : '0);
        return r;
    endfunction

    function automatic blk_t len_blk(input logic [63:0] aad_bits, input logic [63:0] data_bits);
        return {aad_bits, data_bits};
    endfunction

endpackage

// File: rtl/gcm_gf128_mul_ds.sv
// Digit-serial GF(2^128) multiplier: Z = X*H in 128/DIGIT_W cycles after start_i.
// done_o and z_o are the combinational result of the final digit, valid in the done cycle.
module gcm_gf128_mul_ds
    import gcm_pkg::*;
#(
    parameter int DIGIT_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [127:0] x_i,
    input  logic [127:0] h_i,
    output logic         done_o,
    output logic [127:0] z_o
);
    localparam int N  = 128 / DIGIT_W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    blk_t          x_q, z_q, v_q;
    logic          busy_q;
    logic [CW-1:0] cnt_q;
    gf_zv_t        zv [DIGIT_W+1];

    assign zv[0] = '{z: z_q, v: v_q};

    // DIGIT_W unrolled bit iterations per cycle, X consumed MSB first.
    for (genvar gi = 0; gi < DIGIT_W; gi++) begin : g_step
        assign zv[gi+1] = gf128_step(zv[gi], x_q[127-gi]);
    end

    assign z_o    = zv[DIGIT_W].z;
    assign done_o = busy_q && (cnt_q == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q    <= '0;
            z_q    <= '0;
            v_q    <= '0;
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start_i) begin
            x_q    <= x_i;
            z_q    <= '0;
            v_q    <= h_i;
            busy_q <= 1'b1;
            cnt_q  <= '0;
        end else if (busy_q) begin
            x_q   <= x_q << DIGIT_W;
            z_q   <= zv[DIGIT_W].z;
            v_q   <= zv[DIGIT_W].v;
            cnt_q <= cnt_q + CW'(1);
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/gcm_ghash_ds.sv
// GHASH/tag engine: accumulates masked AAD/ciphertext blocks, multiplies in the length block,
// XORs with E(K,J0) and optionally compares against a supplied tag.
module gcm_ghash_ds
    import gcm_pkg::*;
#(
    parameter int DIGIT_W = 8,
    parameter int LEN_W   = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ghash_h_vld_i,
    input  logic [127:0] ghash_h_i,
    input  logic         ghash_decrypt_i,
    input  logic         ghash_ek0_vld_i,
    input  logic [127:0] ghash_ek0_i,
    input  logic         ghash_tag_vld_i,
    input  logic [127:0] ghash_tag_i,
    input  logic         ghash_blk_vld_i,
    input  logic [127:0] ghash_blk_i,
    input  logic         ghash_blk_aad_i,
    input  logic [3:0]   ghash_blk_bytes_i,
    input  logic         ghash_end_i,
    output logic         ghash_ready_o,
    output logic         ghash_tag_vld_o,
    output logic [127:0] ghash_tag_o,
    output logic         ghash_ok_vld_o,
    output logic         ghash_ok_o,
    output logic         ghash_err_o
);
    ghash_state_e     state_q;
    blk_t             y_q, h_q, ek0_q, exp_tag_q, tag_q;
    logic             dec_q, ek0_have_q, tag_have_q, pend_end_q, seen_data_q, err_q, ok_q;
    logic [LEN_W-1:0] aad_bits_q, data_bits_q;

    logic [4:0]       nbytes;
    logic [LEN_W-1:0] add_bits;
    blk_t             blk_masked, len_now, tag_calc, mul_x, mul_z;
    logic             aad_bad, blk_ok, fire, tag_match, mul_start, mul_done;

    assign nbytes   = (ghash_blk_bytes_i == 4'd0) ? 5'd16 : {1'b0, ghash_blk_bytes_i};
    assign add_bits = LEN_W'({nbytes, 3'b000});

    for (genvar gi = 0; gi < 16; gi++) begin : g_mask
        assign blk_masked[127-8*gi -: 8] = (5'(gi) < nbytes) ? ghash_blk_i[127-8*gi -: 8] : 8'h00;
    end

    assign len_now   = len_blk(64'(aad_bits_q), 64'(data_bits_q));
    assign aad_bad   = ghash_blk_aad_i & seen_data_q;
    assign blk_ok    = ghash_blk_vld_i & ~aad_bad;
    assign tag_calc  = y_q ^ ek0_q;
    assign tag_match = (tag_calc == exp_tag_q);
    // A concurrent h_vld aborts the message, so it also suppresses the final strobe.
    assign fire = (state_q == FINAL) && ek0_have_q && (tag_have_q || !dec_q) && !ghash_h_vld_i;

    always_comb begin
        mul_start = 1'b0;
        mul_x     = y_q ^ len_now;
        if (!ghash_h_vld_i) begin
            if (state_q == ACCUM) begin
                mul_start = blk_ok | ghash_end_i;
                if (blk_ok) begin
                    mul_x = y_q ^ blk_masked;
                end
            end else if (state_q == MULT && mul_done && pend_end_q) begin
                mul_start = 1'b1;
                mul_x     = mul_z ^ len_now;
            end
        end
    end

    gcm_gf128_mul_ds #(.DIGIT_W(DIGIT_W)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (mul_start),
        .x_i     (mul_x),
        .h_i     (h_q),
        .done_o  (mul_done),
        .z_o     (mul_z)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            y_q         <= '0;
            h_q         <= '0;
            ek0_q       <= '0;
            exp_tag_q   <= '0;
            tag_q       <= '0;
            dec_q       <= 1'b0;
            ek0_have_q  <= 1'b0;
            tag_have_q  <= 1'b0;
            pend_end_q  <= 1'b0;
            seen_data_q <= 1'b0;
            err_q       <= 1'b0;
            ok_q        <= 1'b0;
            aad_bits_q  <= '0;
            data_bits_q <= '0;
        end else if (ghash_h_vld_i) begin
            h_q         <= ghash_h_i;
            dec_q       <= ghash_decrypt_i;
            y_q         <= '0;
            aad_bits_q  <= '0;
            data_bits_q <= '0;
            err_q       <= 1'b0;
            ek0_have_q  <= 1'b0;
            tag_have_q  <= 1'b0;
            pend_end_q  <= 1'b0;
            seen_data_q <= 1'b0;
            state_q     <= ACCUM;
        end else begin
            if (state_q != IDLE) begin
                if (ghash_ek0_vld_i) begin
                    ek0_q      <= ghash_ek0_i;
                    ek0_have_q <= 1'b1;
                end
                if (ghash_tag_vld_i) begin
                    exp_tag_q  <= ghash_tag_i;
                    tag_have_q <= 1'b1;
                end
            end
            case (state_q)
                ACCUM: begin
                    if (ghash_blk_vld_i && aad_bad) begin
                        err_q <= 1'b1;
                        if (ghash_end_i) begin
                            state_q <= LENMUL;
                        end
                    end else if (ghash_blk_vld_i) begin
                        if (ghash_blk_aad_i) begin
                            aad_bits_q <= aad_bits_q + add_bits;
                        end else begin
                            data_bits_q <= data_bits_q + add_bits;
                            seen_data_q <= 1'b1;
                        end
                        pend_end_q <= ghash_end_i;
                        state_q    <= MULT;
                    end else if (ghash_end_i) begin
                        state_q <= LENMUL;
                    end
                end
                MULT: begin
                    if (mul_done) begin
                        y_q        <= mul_z;
                        pend_end_q <= 1'b0;
                        state_q    <= pend_end_q ? LENMUL : ACCUM;
                    end
                end
                LENMUL: begin
                    if (mul_done) begin
                        y_q     <= mul_z;
                        state_q <= FINAL;
                    end
                end
                FINAL: begin
                    if (fire) begin
                        tag_q <= tag_calc;
                        if (dec_q) begin
                            ok_q <= tag_match;
                        end
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ghash_ready_o   = (state_q == ACCUM);
    assign ghash_tag_vld_o = fire;
    assign ghash_tag_o     = fire ? tag_calc : tag_q;
    assign ghash_ok_vld_o  = fire & dec_q;
    assign ghash_ok_o      = (fire & dec_q) ? tag_match : ok_q;
    assign ghash_err_o     = err_q;

endmodule

// File: tb/tb_gcm_ghash_ds.sv
// Scoreboard bench for gcm_ghash_ds: three instances (DIGIT_W 8, 1, 128) driven one at a time,
// expected tags with their strobe cycle queued at issue and checked by a negedge monitor.
`timescale 1ns/1ps
module tb_gcm_ghash_ds;
    localparam int NI = 3;
    localparam logic [127:0] H_K   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] EK0_K = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    localparam logic [127:0] C_K   = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] T_K   = 128'hab6e47d42cec13bdf53a67b21257bddf;
    localparam logic [127:0] A_K   = 128'hfeedfacedeadbeeffeedfacedeadbeef;
    localparam logic [127:0] D_K   = 128'h42831ec2217774244b7221b784d0d49c;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic         h_vld [NI], dec [NI], ek0_vld [NI], tagi_vld [NI], blk_vld [NI], blk_aad [NI], end_i [NI];
    logic [127:0] h [NI], ek0 [NI], tag_in [NI], blk [NI];
    logic [3:0]   bytes [NI];
    logic         ready [NI], tag_vld [NI], ok_vld [NI], ok [NI], err [NI];
    logic [127:0] tag_out [NI];

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int W = (gi == 0) ? 8 : (gi == 1) ? 1 : 128;
        gcm_ghash_ds #(.DIGIT_W(W), .LEN_W(64)) u_dut (
            .clk               (clk),
            .rst_n             (rst_n),
            .ghash_h_vld_i     (h_vld[gi]),
            .ghash_h_i         (h[gi]),
            .ghash_decrypt_i   (dec[gi]),
            .ghash_ek0_vld_i   (ek0_vld[gi]),
            .ghash_ek0_i       (ek0[gi]),
            .ghash_tag_vld_i   (tagi_vld[gi]),
            .ghash_tag_i       (tag_in[gi]),
            .ghash_blk_vld_i   (blk_vld[gi]),
            .ghash_blk_i       (blk[gi]),
            .ghash_blk_aad_i   (blk_aad[gi]),
            .ghash_blk_bytes_i (bytes[gi]),
            .ghash_end_i       (end_i[gi]),
            .ghash_ready_o     (ready[gi]),
            .ghash_tag_vld_o   (tag_vld[gi]),
            .ghash_tag_o       (tag_out[gi]),
            .ghash_ok_vld_o    (ok_vld[gi]),
            .ghash_ok_o        (ok[gi]),
            .ghash_err_o       (err[gi])
        );
    end

    typedef struct {
        int           inst;
        logic [127:0] tag;
        int           at;
        logic         dchk;
        logic         okv;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic int n_of(input int k);
        return 128 / ((k == 0) ? 8 : (k == 1) ? 1 : 128);
    endfunction

    // Reference GF(2^128) product, bit-serial over the GCM bit string.
    function automatic logic [127:0] gmul(input logic [127:0] x, input logic [127:0] y);
        logic [127:0] z = '0;
        logic [127:0] v = y;
        for (int i = 0; i < 128; i++) begin
            if (x[127-i]) z = z ^ v;
            v = v[0] ? ((v >> 1) ^ {8'he1, 120'h0}) : (v >> 1);
        end
        return z;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < NI; k++) begin
            if (tag_vld[k]) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_tag: inst %0d cyc %0d tag %h, required no strobe", k, cyc, tag_out[k]);
                end else begin
                    e = exp_q.pop_front();
                    check("tag_inst", 128'(k), 128'(e.inst));
                    check("tag_cycle", 128'(cyc), 128'(e.at));
                    check("tag_value", tag_out[k], e.tag);
                    check("ok_vld", 128'(ok_vld[k]), 128'(e.dchk));
                    if (e.dchk) check("ok_value", 128'(ok[k]), 128'(e.okv));
                    $display("[TB] inst %0d cyc %0d tag %h ok_vld %0b ok %0b", k, cyc, tag_out[k], ok_vld[k], ok[k]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_msg(input int k, input logic d);
        h_vld[k] = 1'b1; h[k] = H_K; dec[k] = d;
        tick();
        h_vld[k] = 1'b0;
    endtask

    task automatic give_ek0(input int k, input logic [127:0] v);
        ek0_vld[k] = 1'b1; ek0[k] = v;
        tick();
        ek0_vld[k] = 1'b0;
    endtask

    task automatic give_tag(input int k, input logic [127:0] v);
        tagi_vld[k] = 1'b1; tag_in[k] = v;
        tick();
        tagi_vld[k] = 1'b0;
    endtask

    task automatic wait_ready(input int k);
        for (int i = 0; i < 1000 && !ready[k]; i++) tick();
        if (!ready[k]) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: inst %0d ready_o %0b, required 1", k, ready[k]);
        end
    endtask

    task automatic send_blk(input int k, input logic [127:0] d, input logic aad, input logic [3:0] nb,
                            input logic last, output int t);
        wait_ready(k);
        blk_vld[k] = 1'b1; blk[k] = d; blk_aad[k] = aad; bytes[k] = nb; end_i[k] = last;
        t = cyc;
        tick();
        blk_vld[k] = 1'b0; end_i[k] = 1'b0;
    endtask

    task automatic send_end(input int k, output int t);
        wait_ready(k);
        end_i[k] = 1'b1;
        t = cyc;
        tick();
        end_i[k] = 1'b0;
    endtask

    task automatic expect_tag(input int k, input logic [127:0] tg, input int at, input logic d, input logic okv);
        exp_t e;
        e.inst = k; e.tag = tg; e.at = at; e.dchk = d; e.okv = okv;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d strobes outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) tick();
    endtask

    task automatic one_block(input int k, input logic d, input logic [127:0] tg, input logic okv);
        int t;
        start_msg(k, d);
        give_ek0(k, EK0_K);
        if (d) give_tag(k, tg);
        send_blk(k, C_K, 1'b0, 4'd0, 1'b1, t);
        expect_tag(k, T_K, t + 2 * n_of(k) + 1, d, okv);
        drain();
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout: bench did not finish, required finish");
        $fatal(1, "bench watchdog");
    end

    initial begin
        int t, t1, t2, e;
        logic [127:0] exp_tag;
        for (int k = 0; k < NI; k++) begin
            h_vld[k] = 0; dec[k] = 0; ek0_vld[k] = 0; tagi_vld[k] = 0; blk_vld[k] = 0;
            blk_aad[k] = 0; end_i[k] = 0; h[k] = '0; ek0[k] = '0; tag_in[k] = '0; blk[k] = '0; bytes[k] = '0;
        end
        repeat (3) tick();
        for (int k = 0; k < NI; k++)
            check("reset_outputs", {tag_out[k], tag_vld[k], ok_vld[k], ok[k], err[k], ready[k]}, '0);
        rst_n = 1'b1;
        tick();

        // Empty message: tag = EK0 at t+N+1
        start_msg(0, 1'b0);
        give_ek0(0, EK0_K);
        send_end(0, t);
        expect_tag(0, EK0_K, t + n_of(0) + 1, 1'b0, 1'b0);
        drain();

        // One full ciphertext block, encrypt and both decrypt outcomes
        one_block(0, 1'b0, '0, 1'b0);
        one_block(0, 1'b1, T_K, 1'b1);
        one_block(0, 1'b1, T_K ^ 128'd1, 1'b0);

        // Partial block: garbage beyond byte 4 must be masked, data_bits = 32
        exp_tag = gmul(gmul({32'h0388dace, 96'h0}, H_K) ^ {64'd0, 64'd32}, H_K) ^ EK0_K;
        start_msg(0, 1'b0);
        give_ek0(0, EK0_K);
        send_blk(0, {32'h0388dace, 96'hdeadbeef_01234567_89abcdef}, 1'b0, 4'd4, 1'b1, t);
        expect_tag(0, exp_tag, t + 2 * n_of(0) + 1, 1'b0, 1'b0);
        drain();
        start_msg(0, 1'b0);
        give_ek0(0, EK0_K);
        send_blk(0, {32'h0388dace, 96'h0}, 1'b0, 4'd4, 1'b1, t);
        expect_tag(0, exp_tag, t + 2 * n_of(0) + 1, 1'b0, 1'b0);
        drain();

        // AAD block then 9-byte data block, back to back
        exp_tag = gmul(gmul(A_K, H_K) ^ (D_K & {{72{1'b1}}, {56{1'b0}}}), H_K);
        exp_tag = gmul(exp_tag ^ {64'd128, 64'd72}, H_K) ^ EK0_K;
        start_msg(0, 1'b0);
        give_ek0(0, EK0_K);
        send_blk(0, A_K, 1'b1, 4'd0, 1'b0, t1);
        send_blk(0, D_K, 1'b0, 4'd9, 1'b1, t2);
        check("throughput", 128'(t2 - t1), 128'(n_of(0) + 1));
        expect_tag(0, exp_tag, t2 + 2 * n_of(0) + 1, 1'b0, 1'b0);
        drain();

        // AAD after data: dropped, err set, concurrent end honoured via the length path
        start_msg(0, 1'b0);
        give_ek0(0, EK0_K);
        send_blk(0, C_K, 1'b0, 4'd0, 1'b0, t1);
        send_blk(0, A_K, 1'b1, 4'd0, 1'b1, t2);
        check("err_after_aad", 128'(err[0]), 128'd1);
        expect_tag(0, T_K, t2 + n_of(0) + 1, 1'b0, 1'b0);
        drain();
        check("err_sticky", 128'(err[0]), 128'd1);
        start_msg(0, 1'b0);
        check("err_cleared", 128'(err[0]), 128'd0);

        // Abort two cycles into MULT: no strobe, fresh message afterwards
        give_ek0(0, EK0_K);
        send_blk(0, C_K, 1'b0, 4'd0, 1'b1, t);
        tick();
        start_msg(0, 1'b0);
        check("abort_ready", 128'(ready[0]), 128'd1);
        check("abort_err", 128'(err[0]), 128'd0);
        repeat (40) tick();
        give_ek0(0, EK0_K);
        send_end(0, t);
        expect_tag(0, EK0_K, t + n_of(0) + 1, 1'b0, 1'b0);
        drain();

        // Late EK0: strobe one cycle after it, for one cycle only
        start_msg(0, 1'b0);
        send_blk(0, C_K, 1'b0, 4'd0, 1'b1, t);
        e = t + 2 * n_of(0) + 1 + 10;
        while (cyc < e) tick();
        give_ek0(0, EK0_K);
        expect_tag(0, T_K, e + 1, 1'b0, 1'b0);
        drain();
        repeat (10) tick();

        // IDLE ignores block, end and ek0
        blk_vld[0] = 1'b1; end_i[0] = 1'b1; ek0_vld[0] = 1'b1; blk[0] = C_K;
        tick();
        blk_vld[0] = 1'b0; end_i[0] = 1'b0; ek0_vld[0] = 1'b0;
        check("idle_ready", 128'(ready[0]), 128'd0);
        repeat (20) tick();
        check("idle_tag_hold", tag_out[0], T_K);

        // Other digit widths
        one_block(1, 1'b0, '0, 1'b0);
        one_block(2, 1'b0, '0, 1'b0);
        start_msg(2, 1'b0);
        give_ek0(2, EK0_K);
        send_end(2, t);
        expect_tag(2, EK0_K, t + n_of(2) + 1, 1'b0, 1'b0);
        drain();

        check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
